// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types and constants for the two-source FIFO drain arbiter.
package fifo_drain_pkg;

  // Arbiter states: waiting for work, or holding a grant on one of the sources.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Source identifiers carried on m_src.
  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/fifo_drain_arb_out.sv
// drain_out_reg: single-entry output register (data, source id, last flag).
// The slot is free when it is empty or its current beat is taken this cycle,
// which lets a new beat load in the same cycle the old one is handed off.
module drain_out_reg
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_src,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_src,
  output logic             o_last,
  output logic             o_slot_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_src;
  logic             r_last;

  // Load a new beat when one is accepted; otherwise empty the slot once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= SRC0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_src   <= i_src;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_src       = r_src;
  assign o_last      = r_last;
  assign o_slot_free = !r_valid || i_ready;

endmodule

// File: rtl/fifo_drain_arb.sv
// fifo_drain_arb: drains two FIFOs into one stream with round-robin grants of
// up to BURST_MAX beats, tagging each beat with its source and marking the
// final beat of a full burst.
// Optional feature macro: DRAIN_ARB_STATS_EN adds saturating per-source
// delivered-beat counters on stat_cnt0 / stat_cnt1.
module fifo_drain_arb
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_signal,
  input  logic             s0_valid,
  input  logic [WIDTH-1:0] s0_data,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [WIDTH-1:0] s1_data,
  output logic             s1_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_src,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy
`ifdef DRAIN_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_cnt0,
  output logic [CNT_W-1:0] stat_cnt1
`endif
);

  localparam int CNT_BW = $clog2(BURST_MAX + 1);
  localparam logic [CNT_BW-1:0] BURST_LIM = CNT_BW'(BURST_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_BW-1:0] r_cnt;
  logic [CNT_BW-1:0] w_cnt_nxt;
  logic [CNT_BW-1:0] w_cnt_inc;
  logic              r_last_src;
  logic              w_last_src_nxt;
  logic              w_slot_free;
  logic              w_gnt_src;
  logic              w_gnt_valid;
  logic              w_oth_valid;
  logic              w_acc;
  logic              w_final;
  logic [WIDTH-1:0]  w_acc_data;

  // A zero-width counter or empty burst is not a meaningful configuration.
  if (BURST_MAX < 1 || CNT_W < 1) begin : g_bad_params
  end

  assign s0_ready = (r_state == GRANT0) && w_slot_free && enable_signal;
  assign s1_ready = (r_state == GRANT1) && w_slot_free && enable_signal;

  // Decode the granted source, the accept and whether it closes a full burst.
  always_comb begin
    w_gnt_src   = (r_state == GRANT1) ? SRC1 : SRC0;
    w_gnt_valid = (w_gnt_src == SRC1) ? s1_valid : s0_valid;
    w_oth_valid = (w_gnt_src == SRC1) ? s0_valid : s1_valid;
    w_acc_data  = (w_gnt_src == SRC1) ? s1_data  : s0_data;
    w_acc       = (s0_valid && s0_ready) || (s1_valid && s1_ready);
    w_cnt_inc   = r_cnt + CNT_BW'(1);
    w_final     = w_acc && (w_cnt_inc == BURST_LIM);
  end

  // Next grant, burst count and round-robin pointer.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_last_src_nxt = r_last_src;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (enable_signal) begin
          if (s0_valid && s1_valid) begin
            w_state_nxt = (r_last_src == SRC1) ? GRANT0 : GRANT1;
          end else if (s0_valid) begin
            w_state_nxt = GRANT0;
          end else if (s1_valid) begin
            w_state_nxt = GRANT1;
          end
        end
      end
      GRANT0, GRANT1: begin
        if (!enable_signal) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_final || !w_gnt_valid) begin
          // Burst over: prefer the other source, else restart on this one.
          w_cnt_nxt      = '0;
          w_last_src_nxt = w_gnt_src;
          if (w_oth_valid) begin
            w_state_nxt = (w_gnt_src == SRC1) ? GRANT0 : GRANT1;
          end else if (w_gnt_valid) begin
            w_state_nxt = r_state;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_acc) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Arbiter state register; source 0 wins the first contested grant after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last_src <= SRC1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last_src <= w_last_src_nxt;
    end
  end

  drain_out_reg #(
    .WIDTH (WIDTH)
  ) u_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_acc),
    .i_data      (w_acc_data),
    .i_src       (w_gnt_src),
    .i_last      (w_final),
    .i_ready     (m_ready),
    .o_valid     (m_valid),
    .o_data      (m_data),
    .o_src       (m_src),
    .o_last      (m_last),
    .o_slot_free (w_slot_free)
  );

  assign busy = (r_state != IDLE) || m_valid;

`ifdef DRAIN_ARB_STATS_EN
  logic [CNT_W-1:0] r_stat0;
  logic [CNT_W-1:0] r_stat1;

  // Count delivered beats per source, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else if (m_valid && m_ready) begin
      if (m_src == SRC0) begin
        if (r_stat0 != '1) r_stat0 <= r_stat0 + CNT_W'(1);
      end else begin
        if (r_stat1 != '1) r_stat1 <= r_stat1 + CNT_W'(1);
      end
    end
  end

  assign stat_cnt0 = r_stat0;
  assign stat_cnt1 = r_stat1;
`else
  // Statistics disabled: no counters and no statistics ports.
`endif

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Testbench for fifo_drain_arb: queue-driven sources, a burst-level reference
// model of the expected output order, and per-scenario checks.
module tb_fifo_drain_arb;
  localparam int WIDTH     = 32;
  localparam int BURST_MAX = 4;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             rst_n, enable_signal, m_ready;
  logic             s0_valid, s1_valid, s0_ready, s1_ready;
  logic [WIDTH-1:0] s0_data, s1_data, m_data;
  logic             m_valid, m_src, m_last, busy;
`ifdef DRAIN_ARB_STATS_EN
  logic [CNT_W-1:0] stat_cnt0, stat_cnt1;
`endif

  fifo_drain_arb #(.WIDTH(WIDTH), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable_signal(enable_signal),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_src(m_src), .m_last(m_last),
    .m_ready(m_ready), .busy(busy)
`ifdef DRAIN_ARB_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc0_cnt, acc1_cnt;
  bit en0, en1;
  logic [WIDTH-1:0] q0[$], q1[$];
  logic [WIDTH-1:0] obs_data[$], exp_data[$];
  logic             obs_src[$], obs_last[$], exp_src[$], exp_last[$];
  int               obs_cyc[$];
  logic             smp_s0r, smp_mv, smp_src, smp_busy;
  logic [WIDTH-1:0] smp_data;

  // One clock: drive sources from queue heads, sample before the edge, pop accepted beats.
  task automatic tick();
    bit a0, a1;
    s0_valid = en0 && (q0.size() > 0);
    s0_data  = (q0.size() > 0) ? q0[0] : '0;
    s1_valid = en1 && (q1.size() > 0);
    s1_data  = (q1.size() > 0) ? q1[0] : '0;
    #1;
    a0 = s0_valid && s0_ready;
    a1 = s1_valid && s1_ready;
    smp_s0r = s0_ready; smp_mv = m_valid; smp_data = m_data;
    smp_src = m_src;    smp_busy = busy;
    if (m_valid && m_ready) begin
      obs_data.push_back(m_data); obs_src.push_back(m_src);
      obs_last.push_back(m_last); obs_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
    if (a0) begin q0.delete(0); acc0_cnt++; end
    if (a1) begin q1.delete(0); acc1_cnt++; end
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_src.delete(); obs_last.delete(); obs_cyc.delete();
    acc0_cnt = 0; acc1_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable_signal = 1'b1; m_ready = 1'b1; en0 = 0; en1 = 0;
    q0.delete(); q1.delete();
    tick(); tick();
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic run_until(input int n, input int budget, output bit done);
    int b = 0;
    while (obs_data.size() < n && b < budget) begin tick(); b++; end
    done = (obs_data.size() >= n);
  endtask

  // Reference: alternate grants (source 0 first), each burst up to BURST_MAX
  // beats, shortened when its queue runs dry; a lone source keeps the grant.
  task automatic model_from_queues();
    logic [WIDTH-1:0] m0[$], m1[$];
    bit last, pick;
    m0 = q0; m1 = q1; last = 1'b1;
    exp_data.delete(); exp_src.delete(); exp_last.delete();
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) pick = !last;
      else pick = (m0.size() > 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < BURST_MAX; k++) begin
        if (!pick && m0.size() == 0) break;
        if (pick && m1.size() == 0) break;
        exp_data.push_back(pick ? m1[0] : m0[0]);
        exp_src.push_back(pick);
        exp_last.push_back(k == BURST_MAX - 1);
        if (pick) m1.delete(0); else m0.delete(0);
      end
      last = pick;
    end
  endtask

  task automatic test_reset();
    bit done;
    do_reset();
    #1;
    n_tests++;
    if ({m_valid, busy, s0_ready, s1_ready, m_last, m_src} !== 6'b0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v%b b%b r%b%b l%b s%b d%h, expected all zero",
               m_valid, busy, s0_ready, s1_ready, m_last, m_src, m_data);
    end
    @(negedge clk);
    for (int i = 0; i < 10; i++) q0.push_back(32'h300 + i);
    en0 = 1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midburst: got m_valid=%b busy=%b s0_ready=%b, expected 0 0 0",
               m_valid, busy, s0_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete(); q1.delete(); clear_obs();
    for (int i = 0; i < 4; i++) begin q0.push_back(32'hA00 + i); q1.push_back(32'hB00 + i); end
    en0 = 1; en1 = 1;
    run_until(1, 20, done);
    n_tests++;
    if (!done || obs_src[0] !== 1'b0 || obs_data[0] !== 32'hA00) begin
      n_fail++;
      $display("FAIL reset_first_grant: got done=%0d src=%b data=%h, expected src=0 data=a00",
               done, done ? obs_src[0] : 1'bx, done ? obs_data[0] : 'x);
    end
  endtask

  task automatic test_alternation();
    bit done;
    do_reset();
    for (int i = 0; i < 20; i++) begin q0.push_back(32'h100 + i); q1.push_back(32'h200 + i); end
    en0 = 1; en1 = 1;
    model_from_queues();
    run_until(16, 60, done);
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL alt_timeout: got %0d beats, expected 16", obs_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (obs_data[i] !== exp_data[i] || obs_src[i] !== exp_src[i] || obs_last[i] !== exp_last[i] ||
            obs_src[i] !== 1'((i / 4) % 2) || obs_last[i] !== (i % 4 == 3)) begin
          n_fail++;
          $display("FAIL alt_beat%0d: got d=%h s=%b l=%b, expected d=%h s=%b l=%b",
                   i, obs_data[i], obs_src[i], obs_last[i], exp_data[i], exp_src[i], exp_last[i]);
        end
      end
      n_tests++;
      if (obs_cyc[15] - obs_cyc[0] !== 15) begin
        n_fail++;
        $display("FAIL alt_bubbles: got span %0d cycles for 16 beats, expected 15", obs_cyc[15] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_single_source();
    bit done;
    do_reset();
    for (int i = 0; i < 10; i++) q1.push_back(32'h10 + i);
    en1 = 1;
    model_from_queues();
    run_until(10, 40, done);
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL s1_timeout: got %0d beats, expected 10", obs_data.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (obs_data[i] !== exp_data[i] || obs_src[i] !== 1'b1 || obs_last[i] !== exp_last[i]) begin
          n_fail++;
          $display("FAIL s1_beat%0d: got d=%h s=%b l=%b, expected d=%h s=1 l=%b",
                   i, obs_data[i], obs_src[i], obs_last[i], exp_data[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit done;
    logic [WIDTH-1:0] hold;
    do_reset();
    for (int i = 0; i < 12; i++) q0.push_back(32'h40 + i);
    en0 = 1;
    model_from_queues();
    run_until(2, 20, done);
    m_ready = 1'b0;
    hold = m_data;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_tests++;
      if (smp_mv !== 1'b1 || smp_data !== hold || smp_src !== 1'b0 || smp_s0r !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h s=%b rdy=%b, expected v=1 d=%h s=0 rdy=0",
                 t, smp_mv, smp_data, smp_src, smp_s0r, hold);
      end
    end
    m_ready = 1'b1;
    run_until(12, 60, done);
    n_tests++;
    if (!done || obs_data.size() != 12) begin
      n_fail++; $display("FAIL bp_count: got %0d beats, expected 12", obs_data.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_tests++;
        if (obs_data[i] !== exp_data[i] || obs_src[i] !== 1'b0 || obs_last[i] !== exp_last[i]) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got d=%h l=%b, expected d=%h l=%b",
                   i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    bit done;
    int b = 0;
    do_reset();
    for (int i = 0; i < 10; i++) q0.push_back(32'h50 + i);
    en0 = 1;
    while (acc0_cnt < 2 && b < 20) begin tick(); b++; end
    enable_signal = 1'b0;
    tick();
    n_tests++;
    if (smp_s0r !== 1'b0 || obs_data.size() != 2) begin
      n_fail++;
      $display("FAIL en_drop: got s0_ready=%b delivered=%0d, expected 0 and 2", smp_s0r, obs_data.size());
    end
    tick();
    n_tests++;
    if (smp_busy !== 1'b0 || smp_s0r !== 1'b0) begin
      n_fail++; $display("FAIL en_idle: got busy=%b s0_ready=%b, expected 0 0", smp_busy, smp_s0r);
    end
    tick(); tick(); tick();
    n_tests++;
    if (acc0_cnt != 2) begin
      n_fail++; $display("FAIL en_no_accept: got %0d accepts, expected 2", acc0_cnt);
    end
    enable_signal = 1'b1;
    run_until(10, 40, done);
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL en_timeout: got %0d beats, expected 10", obs_data.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (obs_data[i] !== 32'h50 + i || obs_last[i] !== (i >= 2 && (i - 2) % 4 == 3)) begin
          n_fail++;
          $display("FAIL en_beat%0d: got d=%h l=%b, expected d=%h l=%b", i, obs_data[i], obs_last[i],
                   32'h50 + i, (i >= 2 && (i - 2) % 4 == 3));
        end
      end
    end
  endtask

  task automatic test_random();
    bit done;
    int total, b;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      total = $urandom_range(1, 12);
      for (int i = 0; i < total; i++) q0.push_back($urandom);
      total = $urandom_range(0, 12);
      for (int i = 0; i < total; i++) q1.push_back($urandom);
      en0 = 1; en1 = 1;
      model_from_queues();
      total = exp_data.size(); b = 0;
      while (obs_data.size() < total && b < 500) begin
        m_ready = ($urandom_range(0, 3) != 0);
        tick(); b++;
      end
      m_ready = 1'b1;
      done = (obs_data.size() == total);
      n_tests++;
      if (!done) begin
        n_fail++; $display("FAIL rnd%0d_count: got %0d beats, expected %0d", r, obs_data.size(), total);
      end else begin
        for (int i = 0; i < total; i++) begin
          n_tests++;
          if (obs_data[i] !== exp_data[i] || obs_src[i] !== exp_src[i] || obs_last[i] !== exp_last[i]) begin
            n_fail++;
            $display("FAIL rnd%0d_beat%0d: got d=%h s=%b l=%b, expected d=%h s=%b l=%b", r, i,
                     obs_data[i], obs_src[i], obs_last[i], exp_data[i], exp_src[i], exp_last[i]);
          end
        end
      end
    end
  endtask

`ifdef DRAIN_ARB_STATS_EN
  task automatic test_stats();
    bit done;
    do_reset();
    for (int i = 0; i < 20; i++) q0.push_back(32'h700 + i);
    en0 = 1;
    run_until(20, 80, done);
    tick();
    n_tests++;
    if (!done || stat_cnt0 !== 4'd15 || stat_cnt1 !== 4'd0) begin
      n_fail++;
      $display("FAIL stats: got cnt0=%0d cnt1=%0d beats=%0d, expected 15 0 20",
               stat_cnt0, stat_cnt1, obs_data.size());
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; enable_signal = 1'b0; m_ready = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
    en0 = 0; en1 = 0;
    @(negedge clk);
    test_reset();
    test_alternation();
    test_single_source();
    test_backpressure();
    test_enable_drop();
    test_random();
`ifdef DRAIN_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arb.md
Name: fifo_drain_arb

Overview:
- Downstream of two parallel `fifo` instances; drains both into a single `controller` data input.
- Round-robin arbitration with a bounded burst length per grant.
- Valid/ready handshake on both sides; one registered output stage.
- Tags every beat with its source id and marks the final beat of a full burst.

Parameters:
- WIDTH, 32, data width of both inputs and the output.
- BURST_MAX, 4, maximum beats per grant (≥1); 1 = strict per-beat alternation.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable_signal  in  1  arbitration enable.
- s0_valid  in  1  source 0 (fifo1) data valid.
- s0_data  in  WIDTH  source 0 data.
- s0_ready  out  1  source 0 pop.
- s1_valid  in  1  source 1 (fifo2) data valid.
- s1_data  in  WIDTH  source 1 data.
- s1_ready  out  1  source 1 pop.
- m_valid  out  1  output beat valid.
- m_data  out  WIDTH  output beat data.
- m_src  out  1  source id of the output beat.
- m_last  out  1  beat is the BURST_MAX-th of its grant.
- m_ready  in  1  consumer accept.
- busy  out  1  state != IDLE or m_valid.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, burst count 0, last_src=1 (so source 0 wins first). In-flight output beat is discarded.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - No valid inputs or enable_signal=0: stay in IDLE.
  - Exactly one source valid: grant it.
  - Both valid: grant !last_src.
  - The grant takes effect next cycle; no accept occurs in IDLE.
- Output slot free: m_valid=0, or m_ready=1 in the same cycle.
- sX_ready is asserted only when all three hold: state GRANTX, slot free, enable_signal=1. s(other)_ready=0.
- Accept (sX_valid && sX_ready):
  - m_data, m_src and m_last are registered next cycle; latency 1 cycle.
  - Burst count increments; m_last=1 when the count reaches BURST_MAX.
- Throughput: 1 beat/cycle while m_ready=1.
- m_valid stays high and m_data/m_src/m_last stay stable until m_ready.
- Burst end (count==BURST_MAX after the accept, or granted source drops valid while granted), resolved in the same cycle without a bubble:
  - other source valid → switch to the other grant;
  - else granted source still valid → new burst on the same source;
  - else → IDLE.
  - Count resets to 0 and last_src is updated to the source just served.
- enable_signal falls during a grant:
  - No further accepts.
  - State goes to IDLE next cycle.
  - A pending output beat is still delivered.
- Simultaneous events:
  - Accept on the final burst beat plus a switch: the switch applies next cycle.
  - Output handoff and a new accept in the same cycle are legal (slot-free rule).
- Burst counter width: $clog2(BURST_MAX+1).

Optional Feature:
- Macro: DRAIN_ARB_STATS_EN.
- Defined:
  - Adds output ports stat_cnt0 and stat_cnt1 (CNT_W each).
  - Each counts delivered beats (m_valid && m_ready) by m_src.
  - Counters saturate at all-ones and are cleared by reset only.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package fifo_drain_pkg:
  - state enum (IDLE, GRANT0, GRANT1);
  - source id constants SRC0=0, SRC1=1.
- One sub-module, drain_out_reg:
  - single-entry output register carrying data, src and last;
  - provides the slot-free indication.

Test Plan:
1. Reset mid-burst: s0 streaming, rst_n low for 1 cycle → m_valid=0, busy=0 immediately; after release, s0 is granted first.
2. Both valid, m_ready=1, BURST_MAX=4 → m_src pattern 0,0,0,0,1,1,1,1,0...; m_last on beats 4, 8, ...; no bubbles after the first beat.
3. Only s1 valid, 10 beats, data 0x10..0x19 → output 0x10..0x19 in order, all m_src=1; m_last on beats 4 and 8.
4. Backpressure: m_ready=0 for 5 cycles mid-burst → m_data/m_src held stable; s0_ready=0; no beat lost or duplicated.
5. enable_signal drops after beat 2 of a burst → beat 2 delivered, s0_ready=0 next cycle, state IDLE; re-enable → the burst restarts with count 0.
6. DRAIN_ARB_STATS_EN, CNT_W=4, 20 beats from s0 → stat_cnt0=15 (saturated), stat_cnt1=0.
